// File: rtl/operand_fwd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// operand_fwd_ctrl_pkg
//
// Shared definitions for the operand-forwarding / load-use hazard controller
// of the 5-stage 16-bit pipeline:
//   REG_AW     - register-address width (8 architectural registers)
//   SEL_*      - encodings of the 2-bit EX operand mux selects
//   tag_t      - per-stage destination tag {valid, wr, load, dst}
//   TAG_BUBBLE - tag value of an empty (bubble) pipeline slot
//   pick_sel   - priority encoder turning match flags into a mux select
// ---------------------------------------------------------------------------
package operand_fwd_ctrl_pkg;

  localparam int REG_AW = 3;

  // EX operand mux select encodings.
  localparam logic [1:0] SEL_RF    = 2'b00;  // register file read
  localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB writeback value
  localparam logic [1:0] SEL_IMM   = 2'b11;  // immediate

  typedef struct packed {
    logic              valid;  // slot holds a real instruction
    logic              wr;     // instruction writes the register file
    logic              load;   // instruction is a memory load
    logic [REG_AW-1:0] dst;    // destination register
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  // The producer currently in EX will sit in MEM when the consumer reaches
  // EX, so it is the newest copy and must win over an older MEM producer.
  function automatic logic [1:0] pick_sel(input logic hit_ex,
                                          input logic hit_mem);
    if (hit_ex)       return SEL_EXMEM;
    else if (hit_mem) return SEL_MEMWB;
    else              return SEL_RF;
  endfunction

endpackage

// File: rtl/operand_fwd_ctrl_fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
//
// Combinational comparator: does one source operand read the register that
// one in-flight pipeline tag is going to write?
//
// Ports:
//   src        in  REG_AW  source register number
//   use_src    in  1       operand really reads a register
//   tag_valid  in  1       tag slot holds a real instruction
//   tag_wr     in  1       that instruction writes the register file
//   tag_dst    in  REG_AW  its destination register
//   hit        out 1       RAW dependency on this tag
// ---------------------------------------------------------------------------
module fwd_match
  import operand_fwd_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              tag_valid,
  input  logic              tag_wr,
  input  logic [REG_AW-1:0] tag_dst,
  output logic              hit
);

  // Register 0 is an ordinary register here, so no zero-register exclusion.
  assign hit = tag_valid & tag_wr & use_src & (tag_dst == src);

endmodule

// File: rtl/operand_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// operand_fwd_ctrl
//
// Operand-forwarding and load-use hazard controller. Tracks the destination
// tags of the instructions in EX and MEM, registers the select codes of the
// two EX operand muxes, and raises a decode stall on hazards.
//
// Build option:
//   OPFWD_BYPASS_EN defined   - full forwarding (01 / 10 selects); only a
//                               load-use hazard stalls, for one cycle.
//   OPFWD_BYPASS_EN undefined - no forwarding; selects are 00 or 11 and RAW
//                               hazards stall until the producer is in WB.
//
// Ports:
//   clk           in  1       rising-edge clock
//   rst_n         in  1       synchronous active-low reset
//   id_valid      in  1       decode holds an instruction to issue
//   id_src_a/b    in  REG_AW  source register numbers
//   id_use_a/b    in  1       operand reads a register
//   id_imm_b      in  1       operand B is the immediate (overrides use_b)
//   id_wr_en      in  1       instruction writes the register file
//   id_dst        in  REG_AW  destination register
//   id_is_load    in  1       instruction is a memory load
//   flush         in  1       taken branch: kill decode, bubble into EX
//   stall         out 1       hold PC/IF/ID this cycle (combinational)
//   sel_a/sel_b   out 2       EX operand mux selects (registered)
//   ex_valid      out 1       EX holds a real instruction (registered)
//   stall_cycles  out CNT_W   saturating count of stall cycles
// ---------------------------------------------------------------------------
module operand_fwd_ctrl
  import operand_fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_imm_b,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Tag pipeline. A producer that has reached WB needs no tracking: the
  // register file writes in the first half-cycle, so a reader in decode
  // already sees the value and gets select 00. The entry leaving MEM is
  // therefore simply retired instead of being held in a WB register.
  tag_t ex_tag;
  tag_t mem_tag;
  tag_t issue_tag;

  logic use_b_reg;
  logic hit_a_ex, hit_a_mem, hit_b_ex, hit_b_mem;
  logic hit_ex_any, hit_mem_any;
  logic hazard;
  logic issue;
  logic [1:0] sel_a_d, sel_b_d;

  // An immediate operand B never reads the register file.
  assign use_b_reg = id_use_b & ~id_imm_b;

  fwd_match u_match_a_ex (
    .src       (id_src_a),
    .use_src   (id_use_a),
    .tag_valid (ex_tag.valid),
    .tag_wr    (ex_tag.wr),
    .tag_dst   (ex_tag.dst),
    .hit       (hit_a_ex)
  );

  fwd_match u_match_a_mem (
    .src       (id_src_a),
    .use_src   (id_use_a),
    .tag_valid (mem_tag.valid),
    .tag_wr    (mem_tag.wr),
    .tag_dst   (mem_tag.dst),
    .hit       (hit_a_mem)
  );

  fwd_match u_match_b_ex (
    .src       (id_src_b),
    .use_src   (use_b_reg),
    .tag_valid (ex_tag.valid),
    .tag_wr    (ex_tag.wr),
    .tag_dst   (ex_tag.dst),
    .hit       (hit_b_ex)
  );

  fwd_match u_match_b_mem (
    .src       (id_src_b),
    .use_src   (use_b_reg),
    .tag_valid (mem_tag.valid),
    .tag_wr    (mem_tag.wr),
    .tag_dst   (mem_tag.dst),
    .hit       (hit_b_mem)
  );

  assign hit_ex_any  = hit_a_ex  | hit_b_ex;
  assign hit_mem_any = hit_a_mem | hit_b_mem;

`ifdef OPFWD_BYPASS_EN

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hazard  = 1'b0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    // A load's data only exists after MEM, so an EX-stage load cannot be
    // forwarded yet; one bubble moves it to MEM where 10 picks it up.
    hazard  = ex_tag.load & hit_ex_any;
    sel_a_d = pick_sel(hit_a_ex, hit_a_mem);
    sel_b_d = id_imm_b ? SEL_IMM : pick_sel(hit_b_ex, hit_b_mem);
  end

`else

  // Remaining stall cycles after an EX-stage RAW match: the producer needs
  // two cycles (EX->MEM->WB) before the register file holds its result.
  logic [1:0] hold_cnt;

  always_comb begin
    hazard  = 1'b0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    hazard  = hit_ex_any | hit_mem_any | (hold_cnt != 2'd0);
    if (id_imm_b) sel_b_d = SEL_IMM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      hold_cnt <= 2'd0;
    end else if (stall && hit_ex_any) begin
      hold_cnt <= 2'd1;
    end else if (hold_cnt != 2'd0) begin
      hold_cnt <= hold_cnt - 2'd1;
    end
  end

`endif

  // Flush beats stall: the decode instruction is being killed anyway.
  assign stall = id_valid & ~flush & hazard;
  assign issue = id_valid & ~flush & ~hazard;

  always_comb begin
    issue_tag = TAG_BUBBLE;
    if (issue) begin
      issue_tag.valid = 1'b1;
      issue_tag.wr    = id_wr_en;
      issue_tag.load  = id_is_load;
      issue_tag.dst   = id_dst;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and the EX->MEM shift cannot race.
  // NOTE: reset is synchronous and clears every in-flight tag, so nothing
  // issued before reset can ever be forwarded afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_tag       <= TAG_BUBBLE;
      mem_tag      <= TAG_BUBBLE;
      sel_a        <= SEL_RF;
      sel_b        <= SEL_RF;
      ex_valid     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      mem_tag  <= ex_tag;
      ex_tag   <= issue_tag;
      ex_valid <= issue;
      // A bubble in EX presents neutral selects.
      sel_a    <= issue ? sel_a_d : SEL_RF;
      sel_b    <= issue ? sel_b_d : SEL_RF;
      if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule
